// File: rtl/alu_share_arb.sv
// Time-shares one external combinational ALU between the EXU (requester 0) and the
// address/CSR helper (requester 1) with round-robin priority and one operation in flight.
//
// state | meaning
// IDLE  | waiting for a request; ready is combinational from valid and priority
// EXEC  | operand registers drive the ALU; result captured at the next edge
// RESP  | captured result offered to the granted requester until it takes it
module alu_share_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [DATA_WIDTH-1:0] r0_a,
    input  logic [DATA_WIDTH-1:0] r0_b,
    input  logic [3:0]            r0_ctr,
    output logic                  r0_rvalid,
    input  logic                  r0_rready,
    output logic [DATA_WIDTH-1:0] r0_result,
    output logic                  r0_zero,

    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [DATA_WIDTH-1:0] r1_a,
    input  logic [DATA_WIDTH-1:0] r1_b,
    input  logic [3:0]            r1_ctr,
    output logic                  r1_rvalid,
    input  logic                  r1_rready,
    output logic [DATA_WIDTH-1:0] r1_result,
    output logic                  r1_zero,

    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_ctr,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_zero,

    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_prio;
    logic                  r_gnt;
    logic [DATA_WIDTH-1:0] r_op_a;
    logic [DATA_WIDTH-1:0] r_op_b;
    logic [3:0]            r_op_ctr;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic [CNT_WIDTH-1:0]  r_op_cnt;

    logic                  w_r0_ready;
    logic                  w_r1_ready;
    logic                  w_resp_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_r0_ready  = 1'b0;
        w_r1_ready  = 1'b0;
        w_resp_done = 1'b0;
        case (r_state)
            IDLE: begin
                // A lone requester wins regardless of priority; ties go to r_prio.
                w_r0_ready = r0_valid & (~r1_valid | ~r_prio);
                w_r1_ready = r1_valid & (~r0_valid |  r_prio);
                if (w_r0_ready || w_r1_ready) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                w_resp_done = r_gnt ? r1_rready : r0_rready;
                if (w_resp_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_ctr <= '0;
            r_gnt    <= 1'b0;
        end else if (w_r0_ready) begin
            r_op_a   <= r0_a;
            r_op_b   <= r0_b;
            r_op_ctr <= r0_ctr;
            r_gnt    <= 1'b0;
        end else if (w_r1_ready) begin
            r_op_a   <= r1_a;
            r_op_b   <= r1_b;
            r_op_ctr <= r1_ctr;
            r_gnt    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (r_state == EXEC) begin
            r_result <= alu_out;
            r_zero   <= alu_zero;
        end
    end

    // Priority only moves on completion, so an aborted or stalled op never skips a turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio   <= 1'b0;
            r_op_cnt <= '0;
        end else if (w_resp_done) begin
            r_prio   <= ~r_gnt;
            r_op_cnt <= r_op_cnt + 1'b1;
        end
    end

    assign r0_ready  = w_r0_ready;
    assign r1_ready  = w_r1_ready;

    assign r0_rvalid = (r_state == RESP) & ~r_gnt;
    assign r1_rvalid = (r_state == RESP) &  r_gnt;
    assign r0_result = r0_rvalid ? r_result : '0;
    assign r1_result = r1_rvalid ? r_result : '0;
    assign r0_zero   = r0_rvalid & r_zero;
    assign r1_zero   = r1_rvalid & r_zero;

    assign alu_a     = r_op_a;
    assign alu_b     = r_op_b;
    assign alu_ctr   = r_op_ctr;

    assign busy      = (r_state != IDLE);
    assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a reference ALU closes the loop, and expected
// responses are queued at stimulus time and popped when a response is offered.
module tb_alu_share_arb;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_valid, r0_ready, r0_rvalid, r0_rready, r0_zero;
    logic [DW-1:0] r0_a, r0_b, r0_result;
    logic [3:0]    r0_ctr;
    logic          r1_valid, r1_ready, r1_rvalid, r1_rready, r1_zero;
    logic [DW-1:0] r1_a, r1_b, r1_result;
    logic [3:0]    r1_ctr;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [3:0]    alu_ctr;
    logic          alu_zero;
    logic          busy;
    logic [CW-1:0] op_cnt;

    always #5 clk = ~clk;

    alu_share_arb #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_ctr(r0_ctr),
        .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_result(r0_result), .r0_zero(r0_zero),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_ctr(r1_ctr),
        .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_result(r1_result), .r1_zero(r1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_out(alu_out), .alu_zero(alu_zero),
        .busy(busy), .op_cnt(op_cnt)
    );

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [3:0] c);
        case (c)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
            4'b0011: return {{(DW-1){1'b0}}, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return $signed(a) >>> b[4:0];
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return '0;
        endcase
    endfunction

    assign alu_out  = alu_f(alu_a, alu_b, alu_ctr);
    assign alu_zero = (alu_out == '0);

    typedef struct packed {
        logic          req;
        logic [DW-1:0] res;
        logic          zero;
    } exp_t;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    logic [CW-1:0] m_cnt;
    exp_t          e_front;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int req, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [3:0] c);
        if (req == 0) begin
            r0_valid = 1'b1; r0_a = a; r0_b = b; r0_ctr = c;
        end else begin
            r1_valid = 1'b1; r1_a = a; r1_b = b; r1_ctr = c;
        end
    endtask

    task automatic push(input int req, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [3:0] c);
        exp_t e;
        e.req  = (req != 0);
        e.res  = alu_f(a, b, c);
        e.zero = (e.res == '0);
        sb.push_back(e);
    endtask

    // Returns one edge after the handshake, i.e. with the DUT in EXEC.
    task automatic wait_ready(input int req);
        int n = 0;
        #1;
        while (!(req == 0 ? r0_ready : r1_ready) && n < 20) begin
            tick();
            n++;
        end
        chk("ready_seen", (req == 0) ? r0_ready : r1_ready, 1);
        tick();
    endtask

    task automatic wait_resp();
        int   n = 0;
        exp_t e;
        while (!(r0_rvalid || r1_rvalid) && n < 20) begin
            tick();
            n++;
        end
        chk("sb_nonempty", (sb.size() != 0), 1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk("resp_valid",   e.req ? r1_rvalid : r0_rvalid, 1);
        chk("resp_other",   e.req ? r0_rvalid : r1_rvalid, 0);
        chk("resp_result",  e.req ? r1_result : r0_result, e.res);
        chk("resp_zero",    e.req ? r1_zero   : r0_zero,   e.zero);
        chk("other_result", e.req ? r0_result : r1_result, 0);
        if (e.req) r1_rready = 1'b1; else r0_rready = 1'b1;
        tick();
        m_cnt = m_cnt + 1'b1;
        chk("op_cnt", op_cnt, m_cnt);
    endtask

    task automatic single_op(input int req, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [3:0] c);
        drive(req, a, b, c);
        push(req, a, b, c);
        wait_ready(req);
        chk("exec_alu_a",   alu_a, a);
        chk("exec_alu_b",   alu_b, b);
        chk("exec_alu_ctr", alu_ctr, c);
        chk("exec_busy",    busy, 1);
        if (req == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
        wait_resp();
    endtask

    initial begin
        rst_n = 1'b0;
        r0_valid = 0; r0_a = '0; r0_b = '0; r0_ctr = '0; r0_rready = 0;
        r1_valid = 0; r1_a = '0; r1_b = '0; r1_ctr = '0; r1_rready = 0;
        m_cnt = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_op_cnt", op_cnt, 0);
        chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_ctr", alu_ctr, 0);
        rst_n = 1'b1;

        // r0 alone: 5 + 7
        drive(0, 5, 7, 4'b0000);
        push(0, 5, 7, 4'b0000);
        r0_rready = 1'b1;
        #1;
        chk("t1_r0_ready", r0_ready, 1);
        chk("t1_r1_ready", r1_ready, 0);
        tick();
        chk("t1_exec_rvalid", r0_rvalid, 0);
        chk("t1_exec_ready", r0_ready, 0);
        r0_valid = 1'b0;
        tick();
        chk("t1_rvalid", r0_rvalid, 1);
        chk("t1_result", r0_result, 32'd12);
        wait_resp();
        chk("t1_idle", busy, 0);

        // both valid from reset: strict alternation 0,1,0,1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_cnt = '0;
        drive(0, 9, 9, 4'b1000);
        drive(1, 1, 2, 4'b0000);
        r0_rready = 1'b1; r1_rready = 1'b1;
        push(0, 9, 9, 4'b1000); push(1, 1, 2, 4'b0000);
        push(0, 9, 9, 4'b1000); push(1, 1, 2, 4'b0000);
        #1;
        chk("t2_r0_first", r0_ready, 1);
        chk("t2_r1_wait", r1_ready, 0);
        for (int i = 0; i < 4; i++) wait_resp();
        r0_valid = 1'b0; r1_valid = 1'b0;

        // backpressure on r1 while r0 waits
        r1_rready = 1'b0;
        drive(1, 10, 3, 4'b1000);
        push(1, 10, 3, 4'b1000);
        wait_ready(1);
        r1_valid = 1'b0;
        drive(0, 1, 1, 4'b0000);
        push(0, 1, 1, 4'b0000);
        tick();
        e_front = sb[0];
        for (int i = 0; i < 5; i++) begin
            chk("t3_rvalid_held", r1_rvalid, 1);
            chk("t3_result_held", r1_result, e_front.res);
            chk("t3_r0_blocked", r0_ready, 0);
            chk("t3_cnt_held", op_cnt, m_cnt);
            tick();
        end
        chk("t3_result_7", r1_result, 32'd7);
        wait_resp();
        wait_resp();
        r0_valid = 1'b0;

        // shift pass-through
        single_op(0, 32'h8000_0000, 4, 4'b1101);
        single_op(0, 32'h8000_0000, 4, 4'b0101);
        chk("t4_alu_a_hold", alu_a, 32'h8000_0000);
        chk("t4_alu_ctr_hold", alu_ctr, 4'b0101);

        // async reset during EXEC; priority is 1 here so reset must clear it
        drive(0, 3, 4, 4'b0000);
        wait_ready(0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_rvalid", {r0_rvalid, r1_rvalid}, 0);
        chk("t5_op_cnt", op_cnt, 0);
        chk("t5_alu_a", alu_a, 0);
        r0_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        m_cnt = '0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_resp", {r0_rvalid, r1_rvalid}, 0);
            tick();
        end
        drive(0, 0, 0, 4'b0000);
        drive(1, 6, 2, 4'b1000);
        #1;
        chk("t5_prio0_r0", r0_ready, 1);
        chk("t5_prio0_r1", r1_ready, 0);
        r0_valid = 1'b0;
        single_op(1, 6, 2, 4'b1000);

        // op_cnt wrap with 2-bit counter: 1 then 2,3,0,1; includes an illegal code
        single_op(0, 32'hF0, 32'h0F, 4'b0110);
        single_op(1, 32'hF0, 32'h3C, 4'b0111);
        single_op(0, 5, 5, 4'b1111);
        single_op(1, 1, 31, 4'b0001);
        chk("t6_op_cnt_final", op_cnt, 1);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
